bilinear_seq_core: RTL and testbench

//  Sequential bilinear interpolation core; downstream compute stage of the downscaling controller.

---
 rtl/bilinear_pkg.sv | 25 ++
 rtl/bilinear_mac.sv | 30 +++
 rtl/bilinear_seq_core.sv | 135 +++++++++++++
 tb/tb_bilinear_seq_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bilinear_pkg.sv
// Shared types and constants for the sequential bilinear interpolation core.
package bilinear_pkg;

    localparam int PIX_W     = 8;
    localparam int FRAC_BITS = 8;
    localparam int ONE       = 1 << FRAC_BITS;
    localparam int ROUND     = 1 << 15;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        OUT
    } state_t;

    // Weights at or above ONE select the far pixel only.
    function automatic logic [8:0] clamp_w(input logic [15:0] w);
        return (w > 16'(ONE)) ? 9'(ONE) : w[8:0];
    endfunction

endpackage

// File: rtl/bilinear_mac.sv
// Registered 17x9 multiply-accumulate with clear/accumulate select and an additive constant.
module bilinear_mac (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [16:0] a,
    input  logic [8:0]  b,
    input  logic [15:0] k,
    output logic [24:0] acc
);

    logic [24:0] base;
    logic [24:0] a_ext;
    logic [24:0] b_ext;

    assign base  = clear ? '0 : acc;
    assign a_ext = {8'b0, a};
    assign b_ext = {16'b0, b};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + a_ext * b_ext + {9'b0, k};
        end
    end

endmodule

// File: rtl/bilinear_seq_core.sv
// Sequential bilinear interpolation: one shared MAC over six cycles, rounded 8-bit result.
// Optional BILINEAR_PERF_CNT_EN adds completed-op and busy-cycle counters.
module bilinear_seq_core
    import bilinear_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_p1,
    input  logic [7:0]  i_p2,
    input  logic [7:0]  i_p3,
    input  logic [7:0]  i_p4,
    input  logic [15:0] i_wx,
    input  logic [15:0] i_wy,
`ifdef BILINEAR_PERF_CNT_EN
    output logic [31:0] o_op_count,
    output logic [31:0] o_busy_cycles,
`endif
    output logic        o_busy,
    output logic        o_valid,
    output logic [7:0]  o_result
);

    state_t      state;
    state_t      state_next;

    logic [7:0]  p1, p2, p3, p4;
    logic [8:0]  wx, wy, iwx, iwy;
    logic [16:0] h0, h1;

    logic        mac_en;
    logic        mac_clear;
    logic [16:0] mac_a;
    logic [8:0]  mac_b;
    logic [15:0] mac_k;
    logic [24:0] acc;
    logic        acc_msb_unused;

    assign acc_msb_unused = acc[24];
    assign o_busy         = (state != IDLE);

    bilinear_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .clear (mac_clear),
        .a     (mac_a),
        .b     (mac_b),
        .k     (mac_k),
        .acc   (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        mac_en     = 1'b0;
        mac_clear  = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        mac_k      = '0;
        case (state)
            IDLE: if (i_start) state_next = M0;
            M0: begin
                mac_en = 1'b1; mac_clear = 1'b1; mac_a = {9'b0, p1}; mac_b = iwx;
                state_next = M1;
            end
            M1: begin
                mac_en = 1'b1; mac_a = {9'b0, p2}; mac_b = wx;
                state_next = M2;
            end
            M2: begin
                mac_en = 1'b1; mac_clear = 1'b1; mac_a = {9'b0, p3}; mac_b = iwx;
                state_next = M3;
            end
            M3: begin
                mac_en = 1'b1; mac_a = {9'b0, p4}; mac_b = wx;
                state_next = M4;
            end
            M4: begin
                mac_en = 1'b1; mac_clear = 1'b1; mac_a = h0; mac_b = iwy;
                state_next = M5;
            end
            M5: begin
                mac_en = 1'b1; mac_a = h1; mac_b = wy; mac_k = 16'(ROUND);
                state_next = OUT;
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // h0 sits in the accumulator during M2 and h1 during M4; capture them as the MAC restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0; p2 <= '0; p3 <= '0; p4 <= '0;
            wx <= '0; wy <= '0; iwx <= '0; iwy <= '0;
            h0 <= '0; h1 <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                p1  <= i_p1;
                p2  <= i_p2;
                p3  <= i_p3;
                p4  <= i_p4;
                wx  <= clamp_w(i_wx);
                wy  <= clamp_w(i_wy);
                iwx <= 9'(ONE) - clamp_w(i_wx);
                iwy <= 9'(ONE) - clamp_w(i_wy);
            end
            if (state == M2) h0 <= acc[16:0];
            if (state == M4) h1 <= acc[16:0];
            o_valid <= (state == OUT);
            if (state == OUT) o_result <= acc[23:16];
        end
    end

`ifdef BILINEAR_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_op_count    <= '0;
            o_busy_cycles <= '0;
        end else begin
            o_op_count    <= o_op_count + 32'(state == OUT);
            o_busy_cycles <= o_busy_cycles + 32'(o_busy);
        end
    end
`endif

endmodule

// File: tb/tb_bilinear_seq_core.sv
// Self-checking bench for bilinear_seq_core: arithmetic reference model plus directed vectors.
module tb_bilinear_seq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_p1, i_p2, i_p3, i_p4;
    logic [15:0] i_wx, i_wy;
    logic        o_busy;
    logic        o_valid;
    logic [7:0]  o_result;
`ifdef BILINEAR_PERF_CNT_EN
    logic [31:0] o_op_count;
    logic [31:0] o_busy_cycles;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit active    = 1'b0;
    int start_cyc = 0;
    int exp_res   = 0;
    int last_res  = 0;
    int cyc       = 0;

    bilinear_seq_core dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_p1     (i_p1),
        .i_p2     (i_p2),
        .i_p3     (i_p3),
        .i_p4     (i_p4),
        .i_wx     (i_wx),
        .i_wy     (i_wy),
`ifdef BILINEAR_PERF_CNT_EN
        .o_op_count    (o_op_count),
        .o_busy_cycles (o_busy_cycles),
`endif
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model(input int p1, p2, p3, p4, wx, wy);
        int cx, cy, h0, h1;
        cx = (wx > 256) ? 256 : wx;
        cy = (wy > 256) ? 256 : wy;
        h0 = p1 * (256 - cx) + p2 * cx;
        h1 = p3 * (256 - cx) + p4 * cx;
        return (h0 * (256 - cy) + h1 * cy + 32768) / 65536;
    endfunction

    // Every cycle: valid, busy and held result against the model's timeline.
    initial begin
        bit ev, eb;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ev = active && (cyc == start_cyc + 7);
            eb = active && (cyc >= start_cyc) && (cyc < start_cyc + 7);
            if (ev) last_res = exp_res;
            check("valid_track", int'(o_valid), int'(ev));
            check("busy_track", int'(o_busy), int'(eb));
            check("result_track", int'(o_result), last_res);
            if (ev) active = 1'b0;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int p1, p2, p3, p4, wx, wy);
        i_p1 = 8'(p1); i_p2 = 8'(p2); i_p3 = 8'(p3); i_p4 = 8'(p4);
        i_wx = 16'(wx); i_wy = 16'(wy);
    endtask

    // Issues a start; returns at the first falling edge after the start edge with inputs scrambled.
    task automatic start_op(input int p1, p2, p3, p4, wx, wy);
        @(negedge clk);
        drive(p1, p2, p3, p4, wx, wy);
        i_start = 1'b1;
        if (!active) begin
            active    = 1'b1;
            start_cyc = cyc + 1;
            exp_res   = model(p1, p2, p3, p4, wx, wy);
        end
        @(negedge clk);
        i_start = 1'b0;
        drive($urandom_range(255), $urandom_range(255), $urandom_range(255),
              $urandom_range(255), $urandom_range(511), $urandom_range(511));
    endtask

    task automatic wait_valid(input string name, input int exp_lit);
        int n = 0;
        bit seen = 1'b0;
        while (n < 20 && !seen) begin
            @(posedge clk);
            #2;
            n++;
            if (o_valid) seen = 1'b1;
        end
        if (!seen) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_latency"}, n, 7);
            check(name, int'(o_result), exp_lit);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        wait_neg(3);
        check("reset_busy", int'(o_busy), 0);
        check("reset_valid", int'(o_valid), 0);
        check("reset_result", int'(o_result), 0);
        rst = 1'b0;
        wait_neg(2);

        start_op(100, 100, 100, 100, 37, 200);
        wait_valid("flat", 100);
        start_op(10, 20, 30, 40, 64, 192);
        wait_valid("ramp", 28);
        start_op(0, 255, 0, 255, 128, 0);
        wait_valid("round_half", 128);
        start_op(11, 22, 33, 44, 16'h0000, 0);
        wait_valid("sel_p1", 11);
        start_op(11, 22, 33, 44, 16'h0100, 0);
        wait_valid("sel_p2", 22);
        start_op(11, 22, 33, 44, 16'h0300, 16'h0100);
        wait_valid("clamp_p4", 44);
        start_op(200, 50, 7, 180, 90, 33);
        wait_valid("mixed", model(200, 50, 7, 180, 90, 33));

        // Extra starts during M2 and OUT must be ignored.
        start_op(10, 20, 30, 40, 64, 192);
        wait_neg(2);
        drive(255, 255, 255, 255, 0, 0);
        i_start = 1'b1;
        wait_neg(1);
        i_start = 1'b0;
        wait_neg(3);
        i_start = 1'b1;
        @(posedge clk);
        #2;
        check("ignore_valid", int'(o_valid), 1);
        check("ignore_result", int'(o_result), 28);
        @(negedge clk);
        i_start = 1'b0;
        wait_neg(12);
        check("ignore_idle", int'(o_busy), 0);

        // Reset during M3 aborts; the next op must still be correct.
        start_op(0, 255, 0, 255, 128, 0);
        wait_neg(3);
        rst = 1'b1;
        active = 1'b0;
        last_res = 0;
        #1;
        check("abort_busy", int'(o_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_neg(10);
        check("abort_result", int'(o_result), 0);
        start_op(10, 20, 30, 40, 64, 192);
        wait_valid("after_abort", 28);

`ifdef BILINEAR_PERF_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        active = 1'b0;
        last_res = 0;
        @(negedge clk);
        rst = 1'b0;
        start_op(100, 100, 100, 100, 37, 200);
        wait_valid("perf_op1", 100);
        start_op(10, 20, 30, 40, 64, 192);
        wait_valid("perf_op2", 28);
        start_op(0, 255, 0, 255, 128, 0);
        wait_valid("perf_op3", 128);
        check("op_count", int'(o_op_count), 3);
        check("busy_cycles", int'(o_busy_cycles), 21);
        @(negedge clk);
        rst = 1'b1;
        active = 1'b0;
        last_res = 0;
        #1;
        check("op_count_rst", int'(o_op_count), 0);
        check("busy_cycles_rst", int'(o_busy_cycles), 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        wait_neg(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
